// File: rtl/led_pattern_sequencer.sv
// LED pattern sequencer: two debounced push-buttons drive a 4-mode
// pattern engine (OFF, BLINK, SHIFT, COUNT) on an 8-LED bank.
// SW1 advances the mode, SW2 toggles pause/resume. A prescaler sets
// the pattern step rate. All outputs are registered.
module led_pattern_sequencer #(
   parameter int TICK_DIV   = 6000000,
   parameter int DEB_CYCLES = 120000
) (
   input  logic       CLK,
   input  logic       RSTN,
   input  logic       SW1,
   input  logic       SW2,
   output logic [7:0] LED,
   output logic [1:0] MODE,
   output logic       RUN
);

   localparam int DW = $clog2(DEB_CYCLES + 1);
   localparam int PW = $clog2(TICK_DIV);
   localparam logic [DW-1:0] DEB_LAST = DW'(DEB_CYCLES - 1);
   localparam logic [PW-1:0] TICK_LAST = PW'(TICK_DIV - 1);

   typedef enum logic [1:0] {
      M_OFF   = 2'd0,
      M_BLINK = 2'd1,
      M_SHIFT = 2'd2,
      M_COUNT = 2'd3
   } mode_t;

   // Bit 0 carries SW1 (mode), bit 1 carries SW2 (pause/resume).
   logic [1:0]         raw;
   logic [1:0]         sync_a;
   logic [1:0]         sync_b;
   logic [1:0]         deb;
   logic [1:0]         deb_d;
   logic [1:0][DW-1:0] deb_cnt;
   logic [1:0]         press;
   logic               mode_press;
   logic               run_press;

   mode_t              mode_q;
   mode_t              next_mode;
   logic               run_q;
   logic [PW-1:0]      presc;
   logic [7:0]         pat;
   logic [7:0]         step_val;
   logic [7:0]         entry_val;
   logic               tick;

   assign raw = {SW2, SW1};

   // Two-flop synchronizers for the asynchronous button inputs.
   always_ff @(posedge CLK or negedge RSTN) begin
      if (!RSTN) begin
         sync_a <= 2'b00;
         sync_b <= 2'b00;
      end else begin
         sync_a <= raw;
         sync_b <= sync_a;
      end
   end

   // Debounce: accept a new level only after DEB_CYCLES consecutive
   // cycles of disagreement; any agreement restarts the count.
   always_ff @(posedge CLK or negedge RSTN) begin
      if (!RSTN) begin
         deb     <= 2'b00;
         deb_cnt <= '0;
      end else begin
         for (int i = 0; i < 2; i++) begin
            if (sync_b[i] != deb[i]) begin
               if (deb_cnt[i] == DEB_LAST) begin
                  deb[i]     <= sync_b[i];
                  deb_cnt[i] <= '0;
               end else begin
                  deb_cnt[i] <= deb_cnt[i] + 1'b1;
               end
            end else begin
               deb_cnt[i] <= '0;
            end
         end
      end
   end

   // Delayed debounced level, used to detect rising edges (presses).
   always_ff @(posedge CLK or negedge RSTN) begin
      if (!RSTN) begin
         deb_d <= 2'b00;
      end else begin
         deb_d <= deb;
      end
   end

   // One-cycle press pulses on debounced 0->1 only; releases are ignored.
   assign press      = deb & ~deb_d;
   assign mode_press = press[0];
   assign run_press  = press[1];

   // A step tick is the prescaler wrap; a coincident mode change discards it.
   assign tick = run_q && (presc == TICK_LAST) && !mode_press;

   // Next mode, its entry pattern, and the per-mode step function.
   always_comb begin
      next_mode = mode_t'(mode_q + 2'd1);
      entry_val = (next_mode == M_SHIFT) ? 8'h01 : 8'h00;
      step_val  = 8'h00;
      case (mode_q)
         M_OFF:   step_val = 8'h00;
         M_BLINK: step_val = ~pat;
         M_SHIFT: step_val = {pat[6:0], pat[7]};
         M_COUNT: step_val = pat + 8'd1;
         default: step_val = 8'h00;
      endcase
   end

   // Mode state machine, run flag, prescaler and pattern register.
   always_ff @(posedge CLK or negedge RSTN) begin
      if (!RSTN) begin
         mode_q <= M_OFF;
         run_q  <= 1'b1;
         presc  <= '0;
         pat    <= 8'h00;
      end else begin
         if (mode_press) begin
            mode_q <= next_mode;
            pat    <= entry_val;
            presc  <= '0;
         end else begin
            if (run_q) begin
               presc <= (presc == TICK_LAST) ? '0 : presc + 1'b1;
            end
            if (tick) begin
               pat <= step_val;
            end
         end
         if (run_press) begin
            run_q <= ~run_q;
         end
      end
   end

   assign LED  = pat;
   assign MODE = mode_q;
   assign RUN  = run_q;

endmodule

// File: tb/tb_led_pattern_sequencer.sv
// Bench for led_pattern_sequencer with TICK_DIV=4, DEB_CYCLES=3.
// A behavioural model tracks the expected LED/MODE/RUN every cycle
// while directed scenarios and a random button phase drive the inputs.
module tb_led_pattern_sequencer;

   localparam int TICK_DIV   = 4;
   localparam int DEB_CYCLES = 3;

   logic       CLK = 1'b0;
   logic       RSTN;
   logic       SW1;
   logic       SW2;
   logic [7:0] LED;
   logic [1:0] MODE;
   logic       RUN;

   int n_vec = 0;
   int n_err = 0;

   led_pattern_sequencer #(
      .TICK_DIV  (TICK_DIV),
      .DEB_CYCLES(DEB_CYCLES)
   ) dut (
      .CLK (CLK),
      .RSTN(RSTN),
      .SW1 (SW1),
      .SW2 (SW2),
      .LED (LED),
      .MODE(MODE),
      .RUN (RUN)
   );

   always #5 CLK = ~CLK;

   // ---------------- reference model ----------------
   // Button path: raw level reaches the filter two edges later; the
   // filtered level flips once the last DEB_CYCLES filter inputs all
   // disagree with it. A press is a filtered rise, acted on one edge later.
   bit ms_a [2];
   bit ms_b [2];
   bit m_deb [2];
   bit m_debd [2];
   bit hist0 [$];
   bit hist1 [$];
   int m_mode;
   bit m_run;
   int m_presc;
   int m_led;

   function automatic bit all_ne(bit q[$], bit lvl);
      if (q.size() < DEB_CYCLES) return 1'b0;
      foreach (q[i]) if (q[i] == lvl) return 1'b0;
      return 1'b1;
   endfunction

   function automatic int next_pattern(int md, int v);
      case (md)
         1:       return 255 - v;
         2:       return ((v * 2) % 256) + (v / 128);
         3:       return (v + 1) % 256;
         default: return 0;
      endcase
   endfunction

   task automatic model_reset();
      for (int b = 0; b < 2; b++) begin
         ms_a[b] = 0; ms_b[b] = 0; m_deb[b] = 0; m_debd[b] = 0;
      end
      hist0.delete();
      hist1.delete();
      m_mode = 0; m_run = 1; m_presc = 0; m_led = 0;
   endtask

   task automatic model_edge(bit r1, bit r2);
      bit ev1, ev2, tk;
      ev1 = m_deb[0] && !m_debd[0];
      ev2 = m_deb[1] && !m_debd[1];
      tk  = m_run && (m_presc == TICK_DIV - 1);
      if (ev1) begin
         m_mode  = (m_mode + 1) % 4;
         m_led   = (m_mode == 2) ? 1 : 0;
         m_presc = 0;
      end else begin
         if (m_run) m_presc = (m_presc + 1) % TICK_DIV;
         if (tk) m_led = next_pattern(m_mode, m_led);
      end
      if (ev2) m_run = !m_run;
      m_debd[0] = m_deb[0];
      m_debd[1] = m_deb[1];
      hist0.push_back(ms_b[0]);
      hist1.push_back(ms_b[1]);
      if (hist0.size() > DEB_CYCLES) void'(hist0.pop_front());
      if (hist1.size() > DEB_CYCLES) void'(hist1.pop_front());
      if (all_ne(hist0, m_deb[0])) m_deb[0] = ms_b[0];
      if (all_ne(hist1, m_deb[1])) m_deb[1] = ms_b[1];
      ms_b[0] = ms_a[0]; ms_a[0] = r1;
      ms_b[1] = ms_a[1]; ms_a[1] = r2;
   endtask

   // ---------------- checking and driving ----------------
   task automatic chk(string tag, logic [7:0] obs, logic [7:0] exp);
      n_vec++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic step();
      @(posedge CLK);
      model_edge(SW1, SW2);
      #1;
      chk("led", LED, 8'(m_led));
      chk("mode", {6'd0, MODE}, 8'(m_mode));
      chk("run", {7'd0, RUN}, 8'(m_run));
   endtask

   task automatic press(int btn, int hi, int lo);
      if (btn == 0) SW1 = 1'b1; else SW2 = 1'b1;
      repeat (hi) step();
      SW1 = 1'b0;
      SW2 = 1'b0;
      repeat (lo) step();
   endtask

   // Asynchronous reset pulse between clock edges; outputs must clear at once.
   task automatic do_reset();
      SW1 = 1'b0;
      SW2 = 1'b0;
      #2 RSTN = 1'b0;
      #1;
      chk("rst_led", LED, 8'h00);
      chk("rst_mode", {6'd0, MODE}, 8'h00);
      chk("rst_run", {7'd0, RUN}, 8'h01);
      @(negedge CLK);
      RSTN = 1'b1;
      model_reset();
   endtask

   initial begin
      int  mode_saved;
      int  frozen;
      int  n;
      bit  found;
      bit  wrap_seen;
      int  prev_led;
      int  hold1, hold2;

      // Reset asserted before any clock edge.
      RSTN = 1'b1;
      SW1  = 1'b0;
      SW2  = 1'b0;
      model_reset();
      #1 RSTN = 1'b0;
      #1;
      chk("pre_clk_led", LED, 8'h00);
      chk("pre_clk_mode", {6'd0, MODE}, 8'h00);
      chk("pre_clk_run", {7'd0, RUN}, 8'h01);
      @(posedge CLK);
      @(posedge CLK);
      @(negedge CLK);
      RSTN = 1'b1;

      // Idle with buttons low.
      repeat (100) step();
      chk("idle_led", LED, 8'h00);

      // SW1 held high from edge 1 for 10 edges: MODE=1 exactly at edge 6.
      SW1 = 1'b1;
      for (int k = 1; k <= 10; k++) begin
         step();
         if (k == DEB_CYCLES + 2) chk("lat_mode_before", {6'd0, MODE}, 8'h00);
         if (k == DEB_CYCLES + 3) chk("lat_mode_at", {6'd0, MODE}, 8'h01);
      end
      SW1 = 1'b0;
      repeat (30) step();
      chk("blink_mode_after_release", {6'd0, MODE}, 8'h01);

      // From reset, two clean presses give SHIFT; watch the 0x80->0x01 wrap.
      do_reset();
      press(0, 5, 6);
      press(0, 5, 6);
      chk("shift_mode", {6'd0, MODE}, 8'h02);
      wrap_seen = 0;
      prev_led  = LED;
      repeat (40) begin
         step();
         if (prev_led == 8'h80 && LED == 8'h01) wrap_seen = 1;
         prev_led = LED;
      end
      chk("shift_wrap_seen", {7'd0, wrap_seen}, 8'h01);

      // Pause: start SW2 so the press lands while LED=0x04.
      found = 0;
      for (int k = 0; k < 100 && !found; k++) begin
         step();
         if (m_led == 8'h02 && m_presc == 0) found = 1;
      end
      chk("wait_led02", {7'd0, found}, 8'h01);
      press(1, 5, 3);
      chk("paused_run", {7'd0, RUN}, 8'h00);
      frozen = m_presc;
      repeat (60) begin
         step();
         chk("pause_led", LED, 8'h04);
      end
      // Resume and count edges until the next shift step.
      SW2 = 1'b1;
      found = 0;
      for (int k = 0; k < 20 && !found; k++) begin
         step();
         if (k == 4) SW2 = 1'b0;
         if (RUN === 1'b1) found = 1;
      end
      SW2 = 1'b0;
      chk("resume_seen", {7'd0, found}, 8'h01);
      n = 0;
      found = 0;
      for (int k = 0; k < 20 && !found; k++) begin
         step();
         n++;
         if (LED === 8'h08) found = 1;
      end
      chk("resume_steps", 8'(n), 8'(TICK_DIV - frozen));
      repeat (8) step();

      // Bounce on SW1 (2 high, 1 low) then low: no mode change.
      mode_saved = m_mode;
      for (int k = 0; k < 20; k++) begin
         SW1 = ((k % 3) < 2);
         step();
      end
      SW1 = 1'b0;
      repeat (10) step();
      chk("bounce_no_change", {6'd0, MODE}, 8'(mode_saved));
      // Same bounce then stable high: exactly one increment (to COUNT).
      for (int k = 0; k < 20; k++) begin
         SW1 = ((k % 3) < 2);
         step();
      end
      SW1 = 1'b1;
      repeat (10) step();
      SW1 = 1'b0;
      repeat (10) step();
      chk("bounce_one_inc", {6'd0, MODE}, 8'((mode_saved + 1) % 4));

      // COUNT: run past 1024 cycles and see the 0xFF->0x00 wrap.
      wrap_seen = 0;
      prev_led  = LED;
      repeat (1100) begin
         step();
         if (prev_led == 8'hFF && LED == 8'h00) wrap_seen = 1;
         prev_led = LED;
      end
      chk("count_wrap_seen", {7'd0, wrap_seen}, 8'h01);
      press(0, 5, 6);
      chk("mode_wrap_off", {6'd0, MODE}, 8'h00);
      chk("off_led", LED, 8'h00);

      // Back to COUNT, reset asynchronously once LED reaches 0x2A.
      press(0, 5, 6);
      press(0, 5, 6);
      press(0, 5, 6);
      found = 0;
      for (int k = 0; k < 2000 && !found; k++) begin
         step();
         if (LED === 8'h2A) found = 1;
      end
      chk("wait_led2a", {7'd0, found}, 8'h01);
      do_reset();
      repeat (20) step();

      // Random button activity with random hold lengths.
      hold1 = 0;
      hold2 = 0;
      repeat (1500) begin
         if (hold1 == 0) begin
            SW1   = 1'($urandom_range(0, 1));
            hold1 = $urandom_range(1, 8);
         end
         if (hold2 == 0) begin
            SW2   = 1'($urandom_range(0, 1));
            hold2 = $urandom_range(1, 10);
         end
         hold1--;
         hold2--;
         step();
      end

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
